alu_result_queue: RTL and testbench
===================================

# alu_result_queue

Parametrised successor to the execute-stage ALU result selector. It decodes the instruction, picks the final ALU result from the adder, shifter or logic operands, and computes set-condition results (SEQ/SLT/SLE/SCO) from the adder outputs. Each result is registered together with a destination tag into a small result FIFO with valid/ready handshakes on both sides. It sits between the execute-stage datapath and the EX/MEM pipeline register, so memory-stage stalls are absorbed without stalling execute for up to DEPTH results.

## Interface
- WIDTH, 16: datapath width of operands and result (≥ 4).
- DEPTH, 2: result FIFO entries (power of 2, ≥ 2).
- TAG_W, 3: destination-register tag width.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr  in  16  instruction in execute; opcode is instr[15:11], funct is instr[1:0].
- a_afinv, b_afinv  in  WIDTH  adder operands after invert/forward muxing.
- sum  in  WIDTH  adder result (a_afinv + b_afinv + cin).
- cout  in  1  adder carry out.
- shifter  in  WIDTH  shifter result.
- tag_in  in  TAG_W  destination register of the instruction.
- in_valid  in  1  execute presents a result to capture.
- in_ready  out  1  FIFO can accept; equals !full.
- flush  in  1  squash all queued results (branch mispredict).
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes head.
- out_data  out  WIDTH  head result.
- out_tag  out  TAG_W  head tag.
- out_zero  out  1  head result == 0.
- count  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Result select (combinational, opcode = instr[15:11]):
  - 101??: shifter.
  - 010??: instr[12]==0 → sum; 10 → a^b; 11 → a&b.
  - 100??: instr[12:11]==10 → a|b; otherwise → sum.
  - 11010: shifter.
  - 11011: funct 00/01 → sum; 10 → a^b; 11 → a&b.
  - 111??: set result, zero-extended to WIDTH (1 or 0).
  - Any other opcode: sum.
- Set ops assume upstream computes sum = Rs − Rt, with b inverted and cin=1:
  - zero = (sum==0).
  - ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - lt = sum[MSB] ^ ovf.
  - 11100 SEQ → zero; 11101 SLT → lt; 11110 SLE → lt|zero; 11111 SCO → cout.
- out_zero is computed on the selected result at capture time and stored per entry.
- FIFO behaviour:
  - Push when in_valid && in_ready && !flush.
  - Pop when out_valid && out_ready && !flush.
  - Circular read/write pointers wrap modulo DEPTH.
  - count changes by +1 on push only, −1 on pop only, and is unchanged on simultaneous push and pop.
- Full: in_ready=0. in_valid is ignored, and a pop in the same cycle does not let a push through.
- Empty: out_valid=0. out_data, out_tag and out_zero hold their last values and are don't-care to consumers.
- Flush: next edge sets count=0, pointers=0 and out_valid=0. Same-cycle push and pop are discarded.
- Reset mid-operation drops all entries immediately (asynchronous).

## Timing
- Reset values: out_valid=0, in_ready=1, count=0, out_data=0, out_tag=0, out_zero=0, pointers=0.
- Latency: a result captured at edge N appears with out_valid=1 after edge N when the FIFO was empty. No combinational bypass from input to output.
- in_ready and out_valid are derived only from registered state; there is no combinational path from in_valid or out_ready to them.
- Throughput: 1 result/cycle sustained while out_ready=1.
- Ordering: strictly FIFO. Tags and data always stay paired.

## Test plan
- Reset then SUB (11011, funct 01, sum=0x0005) with tag 3 and in_valid for 1 cycle → out_valid next cycle, out_data=0x0005, out_tag=3, out_zero=0, count=1.
- SLT with a=0x7FFF, b=~0x8000 (Rs=0x7FFF, Rt=0x8000), sum=0xFFFF → ovf=1, lt=0, out_data=0x0000, out_zero=1. Repeat with SLE and sum=0 → out_data=0x0001.
- out_ready=0 with 3 valid pushes at DEPTH=2 → in_ready low after 2, third push is held by the source, count=2. Then out_ready=1 → results pop in order, in_ready rises.
- At count=1, push and pop in the same cycle for 10 cycles → count stays 1, outputs advance each cycle.
- flush asserted with count=2 and in_valid=1 → next cycle count=0, out_valid=0, and the flushed input never appears.
- rst pulsed asynchronously between edges with count=2 → out_valid=0 and count=0 immediately. Operation resumes cleanly on the next push.

Source files
------------

// File: rtl/alu_result_queue_if.sv
// Execute-to-EX/MEM result bus: ALU decode inputs, capture handshake, head-of-queue outputs.
// Ports: instr/a_afinv/b_afinv/sum/cout/shifter/tag_in/in_valid/flush/out_ready into the queue;
//        in_ready/out_valid/out_data/out_tag/out_zero/count out of it. slave = queue, master = environment.
interface alu_result_queue_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int TAG_W = 3
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]      instr;
  logic [WIDTH-1:0] a_afinv;
  logic [WIDTH-1:0] b_afinv;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] shifter;
  logic [TAG_W-1:0] tag_in;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic [CW-1:0]    count;

  modport slave (
    input  instr, a_afinv, b_afinv, sum, cout, shifter, tag_in, in_valid, flush, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero, count
  );

  modport master (
    output instr, a_afinv, b_afinv, sum, cout, shifter, tag_in, in_valid, flush, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero, count
  );
endinterface

// File: rtl/alu_result_queue.sv
// ALU result select (adder/shifter/logic/set-condition) feeding a DEPTH-entry result FIFO.
// Latency: result captured at edge N is visible at the head after edge N (no bypass).
// Backpressure: in_ready = !full from registered count; full blocks push even on same-cycle pop.
// Ports: clk, rst (async, active-high), bus (alu_result_queue_if.slave).
module alu_result_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int TAG_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  alu_result_queue_if.slave  bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int MSB = WIDTH - 1;

  logic [4:0]       opcode;
  logic [1:0]       funct;
  logic             zero, ovf, lt, set_bit;
  logic [WIDTH-1:0] result;
  logic             result_zero;
  logic             unused_instr;

  assign opcode       = bus.instr[15:11];
  assign funct        = bus.instr[1:0];
  assign unused_instr = ^bus.instr[10:2];

  // Set ops rely on upstream forming sum = Rs - Rt (b inverted, cin=1), so the
  // signed compare is the sign of the difference corrected by overflow.
  always_comb begin
    zero = (bus.sum == '0);
    ovf  = (bus.a_afinv[MSB] == bus.b_afinv[MSB]) && (bus.sum[MSB] != bus.a_afinv[MSB]);
    lt   = bus.sum[MSB] ^ ovf;
    case (opcode[1:0])
      2'b00:   set_bit = zero;
      2'b01:   set_bit = lt;
      2'b10:   set_bit = lt | zero;
      default: set_bit = bus.cout;
    endcase
  end

  always_comb begin
    result = bus.sum;
    casez (opcode)
      5'b101??: result = bus.shifter;
      5'b010??: begin
        if (!bus.instr[12])       result = bus.sum;
        else if (!bus.instr[11])  result = bus.a_afinv ^ bus.b_afinv;
        else                      result = bus.a_afinv & bus.b_afinv;
      end
      5'b100??: result = (bus.instr[12:11] == 2'b10) ? (bus.a_afinv | bus.b_afinv) : bus.sum;
      5'b11010: result = bus.shifter;
      5'b11011: begin
        case (funct)
          2'b10:   result = bus.a_afinv ^ bus.b_afinv;
          2'b11:   result = bus.a_afinv & bus.b_afinv;
          default: result = bus.sum;
        endcase
      end
      5'b111??: result = {{(WIDTH-1){1'b0}}, set_bit};
      default:  result = bus.sum;
    endcase
    result_zero = (result == '0);
  end

  // FIFO state
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];
  logic             mem_zero [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head_data;
  logic [TAG_W-1:0] head_tag;
  logic             head_zero;
  logic             full, in_ready, out_valid, push, pop;

  assign full      = (count == CW'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (count != '0);
  assign push      = bus.in_valid && in_ready && !bus.flush;
  assign pop       = out_valid && bus.out_ready && !bus.flush;
  assign rd_next   = rd_ptr + PW'(1);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head_data;
  assign bus.out_tag   = head_tag;
  assign bus.out_zero  = head_zero;
  assign bus.count     = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= result;
      mem_tag[wr_ptr]  <= bus.tag_in;
      mem_zero[wr_ptr] <= result_zero;
    end
  end

  // The head is a register that tracks the entry at rd_ptr after each edge, so
  // the outputs keep their last value once the queue drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_data <= '0;
      head_tag  <= '0;
      head_zero <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_next;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // New entry becomes head when the queue is (or is about to be) empty.
      if (push && (count == '0 || (pop && count == CW'(1)))) begin
        head_data <= result;
        head_tag  <= bus.tag_in;
        head_zero <= result_zero;
      end else if (pop && count > CW'(1)) begin
        head_data <= mem_data[rd_next];
        head_tag  <= mem_tag[rd_next];
        head_zero <= mem_zero[rd_next];
      end
    end
  end
endmodule

// File: tb/tb_alu_result_queue.sv
module tb_alu_result_queue;
  typedef struct {
    logic [15:0] d;
    logic [2:0]  t;
    logic        z;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  exp_t exp_cur;
  exp_t sb [$];

  alu_result_queue_if #(.WIDTH(16), .DEPTH(2), .TAG_W(3)) bus ();

  alu_result_queue #(.WIDTH(16), .DEPTH(2), .TAG_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Output monitor + input acceptance tracker, both sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_head: got data %0h tag %0h with empty scoreboard",
                 bus.out_data, bus.out_tag);
      end else if (bus.out_valid && bus.out_ready && !bus.flush) begin
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        if (bus.out_data !== e.d || bus.out_tag !== e.t || bus.out_zero !== e.z) begin
          n_bad++;
          $display("FAIL head: got data %0h tag %0h zero %0b, expected data %0h tag %0h zero %0b",
                   bus.out_data, bus.out_tag, bus.out_zero, e.d, e.t, e.z);
        end
      end
      if (bus.flush) sb.delete();
      else if (bus.in_valid && bus.in_ready) sb.push_back(exp_cur);
    end
  end

  task automatic set_vec(input logic [15:0] instr, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] s, input logic co, input logic [15:0] sh,
                         input logic [2:0] tag, input logic [15:0] expd);
    bus.instr    = instr;
    bus.a_afinv  = a;
    bus.b_afinv  = b;
    bus.sum      = s;
    bus.cout     = co;
    bus.shifter  = sh;
    bus.tag_in   = tag;
    bus.in_valid = 1'b1;
    exp_cur.d    = expd;
    exp_cur.t    = tag;
    exp_cur.z    = (expd == 16'h0000);
  endtask

  // Holds in_valid until the queue accepts; leaves time at posedge+1.
  task automatic wait_accept();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready 0, expected 1 within 50 cycles");
    end
  endtask

  task automatic issue(input logic [15:0] instr, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] s, input logic co, input logic [15:0] sh,
                       input logic [2:0] tag, input logic [15:0] expd);
    set_vec(instr, a, b, s, co, sh, tag, expd);
    wait_accept();
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.instr = '0; bus.a_afinv = '0; bus.b_afinv = '0; bus.sum = '0; bus.cout = 1'b0;
    bus.shifter = '0; bus.tag_in = '0; bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    exp_cur = '{d: 16'h0, t: 3'h0, z: 1'b0};
    #12 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_count", bus.count, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_out_zero", bus.out_zero, 0);
    @(posedge clk); #1;

    // SUB, held at head for direct inspection
    issue(16'hD801, 16'h0009, 16'hFFFB, 16'h0005, 1'b1, 16'h0000, 3'd3, 16'h0005);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sub_out_valid", bus.out_valid, 1);
    chk("sub_out_data", bus.out_data, 16'h0005);
    chk("sub_out_tag", bus.out_tag, 3);
    chk("sub_out_zero", bus.out_zero, 0);
    chk("sub_count", bus.count, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain();

    // Result select and set ops, streaming with out_ready=1
    issue(16'hE800, 16'h7FFF, 16'h7FFF, 16'hFFFF, 1'b0, 16'h0000, 3'd1, 16'h0000); // SLT ovf
    issue(16'hF000, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b1, 16'h0000, 3'd2, 16'h0001); // SLE eq
    issue(16'hE800, 16'h0003, 16'hFFFA, 16'hFFFE, 1'b0, 16'h0000, 3'd4, 16'h0001); // SLT 3<5
    issue(16'hE000, 16'h0003, 16'hFFFA, 16'hFFFE, 1'b0, 16'h0000, 3'd5, 16'h0000); // SEQ ne
    issue(16'hF800, 16'h1234, 16'h1111, 16'h1234, 1'b1, 16'h0000, 3'd6, 16'h0001); // SCO
    issue(16'hA000, 16'hF0F0, 16'h3C3C, 16'h1234, 1'b0, 16'hABCD, 3'd7, 16'hABCD); // shift
    issue(16'h4000, 16'hF0F0, 16'h3C3C, 16'h1234, 1'b0, 16'hABCD, 3'd0, 16'h1234); // 010 sum
    issue(16'h5000, 16'hF0F0, 16'h3C3C, 16'h1234, 1'b0, 16'hABCD, 3'd1, 16'hCCCC); // 010 xor
    issue(16'h5800, 16'hF0F0, 16'h3C3C, 16'h1234, 1'b0, 16'hABCD, 3'd2, 16'h3030); // 010 and
    issue(16'h9000, 16'hF0F0, 16'h3C3C, 16'h1234, 1'b0, 16'hABCD, 3'd3, 16'hFCFC); // 100 or
    issue(16'h8800, 16'hF0F0, 16'h3C3C, 16'h1234, 1'b0, 16'hABCD, 3'd4, 16'h1234); // 100 sum
    issue(16'hD000, 16'hF0F0, 16'h3C3C, 16'h1234, 1'b0, 16'hABCD, 3'd5, 16'hABCD); // 11010
    issue(16'hD802, 16'hF0F0, 16'h3C3C, 16'h1234, 1'b0, 16'hABCD, 3'd6, 16'hCCCC); // 11011 xor
    issue(16'hD803, 16'h0F0F, 16'hF0F0, 16'h1234, 1'b0, 16'hABCD, 3'd7, 16'h0000); // and -> 0
    issue(16'hC000, 16'hF0F0, 16'h3C3C, 16'h4321, 1'b0, 16'hABCD, 3'd0, 16'h4321); // default
    bus.in_valid = 1'b0;
    drain();

    // Full: three pushes with out_ready=0
    bus.out_ready = 1'b0;
    issue(16'h0000, 16'h0, 16'h0, 16'h0A01, 1'b0, 16'h0, 3'd1, 16'h0A01);
    issue(16'h0000, 16'h0, 16'h0, 16'h0A02, 1'b0, 16'h0, 3'd2, 16'h0A02);
    set_vec(16'h0000, 16'h0, 16'h0, 16'h0A03, 1'b0, 16'h0, 3'd3, 16'h0A03);
    @(negedge clk);
    chk("full_count", bus.count, 2);
    chk("full_in_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("full_hold_count", bus.count, 2);
    chk("full_out_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_accept();
    bus.in_valid = 1'b0;
    drain();

    // Simultaneous push/pop at count=1
    bus.out_ready = 1'b0;
    issue(16'h0000, 16'h0, 16'h0, 16'h0100, 1'b0, 16'h0, 3'd0, 16'h0100);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      set_vec(16'h0000, 16'h0, 16'h0, 16'h0100 + 16'(i), 1'b0, 16'h0, 3'(i), 16'h0100 + 16'(i));
      @(negedge clk);
      chk("pp_count", bus.count, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    drain();

    // Flush at count=2 with in_valid, then at count=1 with a pushable input
    bus.out_ready = 1'b0;
    issue(16'h0000, 16'h0, 16'h0, 16'h0B01, 1'b0, 16'h0, 3'd1, 16'h0B01);
    issue(16'h0000, 16'h0, 16'h0, 16'h0B02, 1'b0, 16'h0, 3'd2, 16'h0B02);
    set_vec(16'h0000, 16'h0, 16'h0, 16'hDEAD, 1'b0, 16'h0, 3'd7, 16'hDEAD);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush2_count", bus.count, 0);
    chk("flush2_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(16'h0000, 16'h0, 16'h0, 16'h0C01, 1'b0, 16'h0, 3'd1, 16'h0C01);
    set_vec(16'h0000, 16'h0, 16'h0, 16'hBEEF, 1'b0, 16'h0, 3'd6, 16'hBEEF);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush1_count", bus.count, 0);
    chk("flush1_out_valid", bus.out_valid, 0);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset between edges at count=2
    bus.out_ready = 1'b0;
    issue(16'h0000, 16'h0, 16'h0, 16'h0D01, 1'b0, 16'h0, 3'd1, 16'h0D01);
    issue(16'h0000, 16'h0, 16'h0, 16'h0D02, 1'b0, 16'h0, 3'd2, 16'h0D02);
    bus.in_valid = 1'b0;
    chk("prerst_count", bus.count, 2);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_count", bus.count, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    sb.delete();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    issue(16'hD802, 16'h00FF, 16'h0F0F, 16'h0000, 1'b0, 16'h0, 3'd5, 16'h0FF0);
    bus.in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
